// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, legal prescale values and parity selectors
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } rx_state_e;
    localparam int PRE_8  = 8;
    localparam int PRE_16 = 16;
    localparam int PRE_32 = 32;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    function automatic int norm_pre(input int p);
        return (p == PRE_16 || p == PRE_32) ? p : PRE_8;
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: bit-period edge counter and mid-bit sampler; UART_RX_MAJORITY_EN enables 2-of-3 voting
module uart_rx_sampler #(
    parameter int Pre_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             active,
    input  logic [Pre_W-1:0] pre,
    input  logic             rx_in,
    output logic             sampled_bit,
    output logic             bit_done
);
    localparam logic [Pre_W-1:0] ONE = Pre_W'(1);
    logic [Pre_W-1:0] edge_cnt_q, edge_cnt_d, half;
    logic mid_q, mid_d, bit_q, bit_d, vote;
    assign half        = pre >> 1;
    assign bit_done    = active && edge_cnt_q == pre - ONE;
    assign sampled_bit = bit_q;
`ifdef UART_RX_MAJORITY_EN
    logic early_q, early_d;
    assign early_d = edge_cnt_q == half - ONE ? rx_in : early_q;
    assign vote    = (early_q & mid_q) | (early_q & rx_in) | (mid_q & rx_in);
    always_ff @(posedge CLK) begin
        if (RST) early_q <= 1'b0;
        else     early_q <= early_d;
    end
`else
    assign vote = mid_q;
`endif
    // The voted bit is registered one cycle after the centre so both builds share the same timing
    always_comb begin
        edge_cnt_d = (!active || bit_done) ? '0 : edge_cnt_q + ONE;
        mid_d      = edge_cnt_q == half ? rx_in : mid_q;
        bit_d      = edge_cnt_q == half + ONE ? vote : bit_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt_q <= '0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive frame FSM (start/data/parity/stop); define UART_RX_MAJORITY_EN for 2-of-3 sampling
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int D_Width = 8,
    parameter int Pre_W   = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [Pre_W-1:0]   Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [D_Width-1:0] P_DATA,
    output logic               Data_Valid,
    output logic               Parity_Error,
    output logic               Stop_Error
);
    localparam int BW = $clog2(D_Width + 1);
    rx_state_e state_q, state_d;
    logic [Pre_W-1:0] pre_q, pre_d;
    logic par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [D_Width-1:0] shreg_q, shreg_d, p_data_q, p_data_d;
    logic par_err_q, par_err_d, dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic active, sampled, bit_done, idle_start, last_bit, stop_end;
    assign active = state_q != IDLE;
    uart_rx_sampler #(.Pre_W(Pre_W)) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .active      (active),
        .pre         (pre_q),
        .rx_in       (RX_IN),
        .sampled_bit (sampled),
        .bit_done    (bit_done)
    );
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d  = state_q;
        last_bit = bit_cnt_q == BW'(D_Width - 1);
        case (state_q)
            IDLE:    state_d = !RX_IN ? START : IDLE;
            START:   if (bit_done) state_d = sampled ? IDLE : DATA;
            DATA:    if (bit_done && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) state_d = STOP;
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Frame configuration is frozen at the start edge so mid-frame input changes cannot corrupt timing
    always_comb begin
        idle_start = state_q == IDLE && !RX_IN;
        pre_d      = idle_start ? Pre_W'(norm_pre(32'(Prescale))) : pre_q;
        par_en_d   = idle_start ? PAR_EN : par_en_q;
        par_typ_d  = idle_start ? PAR_TYP : par_typ_q;
        bit_cnt_d  = state_q != DATA ? '0 : bit_done ? bit_cnt_q + BW'(1) : bit_cnt_q;
        shreg_d    = (state_q == DATA && bit_done) ? {sampled, shreg_q[D_Width-1:1]} : shreg_q;
        par_err_d  = state_q == IDLE ? 1'b0
                   : (state_q == PARITY && bit_done) ? sampled != (^shreg_q ^ (par_typ_q == PAR_ODD))
                   : par_err_q;
        stop_end   = state_q == STOP && bit_done;
        dv_d       = stop_end && sampled && !par_err_q;
        pe_d       = stop_end && par_err_q;
        se_d       = stop_end && !sampled;
        p_data_d   = dv_d ? shreg_q : p_data_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q     <= Pre_W'(PRE_8);
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_err_q <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_err_q <= par_err_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end
    assign P_DATA       = p_data_q;
    assign Data_Valid   = dv_q;
    assign Parity_Error = pe_q;
    assign Stop_Error   = se_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frame tests for uart_rx_frame; honours UART_RX_MAJORITY_EN for the glitch case
module tb_uart_rx_frame;
    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic Data_Valid, Parity_Error, Stop_Error;
    int cyc = 0, pe_n = 0, se_n = 0, ovl_n = 0;
    int errors = 0, checks = 0;
    int dv_cyc[$];
    logic [7:0] dv_dat[$];
    int dv0, pe0, se0;
`ifdef UART_RX_MAJORITY_EN
    localparam int GLITCH_BIT = 0;
`else
    localparam int GLITCH_BIT = -1;
`endif
    uart_rx_frame #(.D_Width(8), .Pre_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (Parity_Error) pe_n++;
        if (Stop_Error) se_n++;
        if (Data_Valid && (Parity_Error || Stop_Error)) ovl_n++;
    end
    task automatic mark;
        dv0 = dv_cyc.size();
        pe0 = pe_n;
        se0 = se_n;
    endtask
    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask
    // One line bit of p cycles; cycle g (if any) carries the inverted level
    task automatic drive_bit(input logic b, input int p, input int g);
        for (int i = 0; i < p; i++) begin
            RX_IN = (i == g) ? ~b : b;
            @(posedge CLK);
            #1;
        end
    endtask
    // det = the edge at which the receiver sees the start bit in IDLE
    task automatic send_frame(input logic [7:0] d, input int p, input logic par_en, input logic par_bit,
                              input logic stop_bit, input int gbit, output int det);
        det = cyc + 1;
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, i == gbit ? p / 2 + 1 : -1);
        if (par_en) drive_bit(par_bit, p, -1);
        drive_bit(stop_bit, p, -1);
        RX_IN = 1'b1;
    endtask
    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %0h want 0", P_DATA); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
        checks++; if (Parity_Error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", Parity_Error); end
        checks++; if (Stop_Error !== 1'b0) begin errors++; $display("FAIL reset_se: got %b want 0", Stop_Error); end
        RST = 1'b0;
    endtask
    task automatic test_p8_nopar;
        int det;
        Prescale = 6'd8; PAR_EN = 1'b0; mark();
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1, det);
        idle(4);
        checks++; if (dv_cyc.size() - dv0 != 1) begin errors++; $display("FAIL p8_dv_count: got %0d want 1", dv_cyc.size() - dv0); end
        checks++; if (dv_cyc[dv0] - det != 80) begin errors++; $display("FAIL p8_latency: got %0d want 80", dv_cyc[dv0] - det); end
        checks++; if (dv_dat[dv0] !== 8'hAA) begin errors++; $display("FAIL p8_data_at_dv: got %0h want aa", dv_dat[dv0]); end
        checks++; if (P_DATA !== 8'hAA) begin errors++; $display("FAIL p8_data_held: got %0h want aa", P_DATA); end
        checks++; if (pe_n - pe0 + se_n - se0 != 0) begin errors++; $display("FAIL p8_no_err: got %0d want 0", pe_n - pe0 + se_n - se0); end
    endtask
    task automatic test_parity;
        int det;
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; mark();
        send_frame(8'hCC, 16, 1'b1, 1'b0, 1'b1, -1, det);
        idle(4);
        checks++; if (dv_cyc.size() - dv0 != 1) begin errors++; $display("FAIL par_good_dv: got %0d want 1", dv_cyc.size() - dv0); end
        checks++; if (dv_cyc[dv0] - det != 176) begin errors++; $display("FAIL par_latency: got %0d want 176", dv_cyc[dv0] - det); end
        checks++; if (P_DATA !== 8'hCC) begin errors++; $display("FAIL par_good_data: got %0h want cc", P_DATA); end
        checks++; if (pe_n - pe0 != 0) begin errors++; $display("FAIL par_good_pe: got %0d want 0", pe_n - pe0); end
        mark();
        send_frame(8'hCC, 16, 1'b1, 1'b1, 1'b1, -1, det);
        idle(4);
        checks++; if (pe_n - pe0 != 1) begin errors++; $display("FAIL par_bad_pe: got %0d want 1", pe_n - pe0); end
        checks++; if (dv_cyc.size() - dv0 != 0) begin errors++; $display("FAIL par_bad_dv: got %0d want 0", dv_cyc.size() - dv0); end
        checks++; if (se_n - se0 != 0) begin errors++; $display("FAIL par_bad_se: got %0d want 0", se_n - se0); end
        checks++; if (P_DATA !== 8'hCC) begin errors++; $display("FAIL par_bad_data: got %0h want cc", P_DATA); end
    endtask
    task automatic test_stop_error;
        int det;
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1; mark();
        send_frame(8'hBB, 32, 1'b1, 1'b1, 1'b0, -1, det);
        idle(4);
        checks++; if (se_n - se0 != 1) begin errors++; $display("FAIL stop_se: got %0d want 1", se_n - se0); end
        checks++; if (pe_n - pe0 != 0) begin errors++; $display("FAIL stop_pe: got %0d want 0", pe_n - pe0); end
        checks++; if (dv_cyc.size() - dv0 != 0) begin errors++; $display("FAIL stop_dv: got %0d want 0", dv_cyc.size() - dv0); end
        checks++; if (P_DATA !== 8'hCC) begin errors++; $display("FAIL stop_data: got %0h want cc", P_DATA); end
    endtask
    task automatic test_glitch;
        int det;
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; mark();
        drive_bit(1'b0, 3, -1);
        idle(20);
        checks++; if (dv_cyc.size() - dv0 + pe_n - pe0 + se_n - se0 != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", dv_cyc.size() - dv0 + pe_n - pe0 + se_n - se0); end
        send_frame(8'hDD, 8, 1'b0, 1'b0, 1'b1, -1, det);
        idle(4);
        checks++; if (dv_cyc.size() - dv0 != 1) begin errors++; $display("FAIL glitch_dd_dv: got %0d want 1", dv_cyc.size() - dv0); end
        checks++; if (P_DATA !== 8'hDD) begin errors++; $display("FAIL glitch_dd_data: got %0h want dd", P_DATA); end
    endtask
    // Each re-detect happens one cycle after the previous stop bit ends, so pulses are 80+1 apart
    task automatic test_back_to_back;
        int det;
        Prescale = 6'd8; PAR_EN = 1'b0; mark();
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1, det);
        send_frame(8'h05, 8, 1'b0, 1'b0, 1'b1, -1, det);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, det);
        idle(6);
        checks++; if (dv_cyc.size() - dv0 != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dv_cyc.size() - dv0); end
        checks++; if (dv_dat[dv0] !== 8'hAA) begin errors++; $display("FAIL b2b_data0: got %0h want aa", dv_dat[dv0]); end
        checks++; if (dv_dat[dv0+1] !== 8'h05) begin errors++; $display("FAIL b2b_data1: got %0h want 05", dv_dat[dv0+1]); end
        checks++; if (dv_dat[dv0+2] !== 8'h3C) begin errors++; $display("FAIL b2b_data2: got %0h want 3c", dv_dat[dv0+2]); end
        checks++; if (dv_cyc[dv0+1] - dv_cyc[dv0] != 81) begin errors++; $display("FAIL b2b_gap1: got %0d want 81", dv_cyc[dv0+1] - dv_cyc[dv0]); end
        checks++; if (dv_cyc[dv0+2] - dv_cyc[dv0+1] != 81) begin errors++; $display("FAIL b2b_gap2: got %0d want 81", dv_cyc[dv0+2] - dv_cyc[dv0+1]); end
        checks++; if (ovl_n != 0) begin errors++; $display("FAIL pulse_overlap: got %0d want 0", ovl_n); end
    endtask
    task automatic test_reset_mid;
        int det;
        logic [7:0] d;
        Prescale = 6'd8; PAR_EN = 1'b0; mark();
        d = 8'h7E;
        drive_bit(1'b0, 8, -1);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8, -1);
        RST = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL midrst_pdata: got %0h want 0", P_DATA); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL midrst_dv: got %b want 0", Data_Valid); end
        RST = 1'b0;
        idle(20);
        checks++; if (dv_cyc.size() - dv0 + pe_n - pe0 + se_n - se0 != 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", dv_cyc.size() - dv0 + pe_n - pe0 + se_n - se0); end
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, GLITCH_BIT, det);
        idle(4);
        checks++; if (dv_cyc.size() - dv0 != 1) begin errors++; $display("FAIL after_rst_dv: got %0d want 1", dv_cyc.size() - dv0); end
        checks++; if (P_DATA !== 8'h11) begin errors++; $display("FAIL after_rst_data: got %0h want 11", P_DATA); end
    endtask
    initial begin
        #1;
        test_reset();
        test_p8_nopar();
        test_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
